// File: rtl/deser_pkg.sv
// Shared types and limits for the serial-to-parallel frame deserializer.
// The PAR state exists only when DESER_PARITY_EN is defined.
package deser_pkg;

  localparam int DESER_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CMD
`ifdef DESER_PARITY_EN
    , ST_PAR
`endif
  } deser_state_e;

endpackage

// File: rtl/param_deserializer.sv
// Serial frame deserializer: DATA_W payload bits, a command bit, optional odd parity bit.
// Define DESER_PARITY_EN to add the parity bit, the PAR state and the parity_err_o port.
module param_deserializer
  import deser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              data_val_i,
  input  logic              ser_data_i,
  input  logic              ready_i,
`ifdef DESER_PARITY_EN
  output logic              parity_err_o,
`endif
  output logic [DATA_W-1:0] data_o,
  output logic              command_o,
  output logic              valid_o,
  output logic              overrun_o
);

  localparam int              CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

  deser_state_e      state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic              complete, frame_cmd;

  // Shift direction decides where the first received bit ends up.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sh_nxt = {sh[DATA_W-2:0], ser_data_i};
    end else begin : g_lsb
      assign sh_nxt = {ser_data_i, sh[DATA_W-1:1]};
    end
  endgenerate

`ifdef DESER_PARITY_EN
  logic cmd_q, frame_perr;
  assign complete   = (state == ST_PAR);
  assign frame_cmd  = cmd_q;
  assign frame_perr = ~(^sh ^ cmd_q ^ ser_data_i);
`else
  assign complete   = (state == ST_CMD);
  assign frame_cmd  = ser_data_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sh    <= '0;
`ifdef DESER_PARITY_EN
      cmd_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (data_val_i) begin
          sh    <= sh_nxt;
          cnt   <= CW'(1);
          state <= (DATA_W > 1) ? ST_DATA : ST_CMD;
        end
        ST_DATA: begin
          sh <= sh_nxt;
          // Hold at the last index rather than wrap.
          if (cnt == LAST) state <= ST_CMD;
          else             cnt   <= cnt + CW'(1);
        end
`ifdef DESER_PARITY_EN
        ST_CMD: begin
          cmd_q <= ser_data_i;
          state <= ST_PAR;
        end
        ST_PAR:  state <= ST_IDLE;
`else
        ST_CMD:  state <= ST_IDLE;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: a completing frame may replace a held one only if it is taken this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o       <= '0;
      command_o    <= 1'b0;
      valid_o      <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      overrun_o <= 1'b0;
      if (complete) begin
        if (!valid_o || ready_i) begin
          data_o       <= sh;
          command_o    <= frame_cmd;
          valid_o      <= 1'b1;
`ifdef DESER_PARITY_EN
          parity_err_o <= frame_perr;
`endif
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_deserializer.sv
// Randomized bench for param_deserializer: two instances (MSB-first, LSB-first) checked each cycle
// against a frame-level model of the output register.
module tb_param_deserializer;

`ifdef DESER_PARITY_EN
  localparam int W  = 8;
  localparam int FL = W + 2;
`else
  localparam int W  = 5;
  localparam int FL = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n, data_val, ser, rdy;
  logic [W-1:0] data_a, data_b;
  logic         cmd_a, cmd_b, valid_a, valid_b, ovr_a, ovr_b;
`ifdef DESER_PARITY_EN
  logic         perr_a, perr_b;
`endif

  always #5 clk = ~clk;

  param_deserializer #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .data_val_i(data_val), .ser_data_i(ser), .ready_i(rdy),
`ifdef DESER_PARITY_EN
    .parity_err_o(perr_a),
`endif
    .data_o(data_a), .command_o(cmd_a), .valid_o(valid_a), .overrun_o(ovr_a)
  );

  param_deserializer #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .data_val_i(data_val), .ser_data_i(ser), .ready_i(rdy),
`ifdef DESER_PARITY_EN
    .parity_err_o(perr_b),
`endif
    .data_o(data_b), .command_o(cmd_b), .valid_o(valid_b), .overrun_o(ovr_b)
  );

  int          n_chk = 0, n_err = 0, n_ovr = 0;
  // Reference model: bits of the frame in flight and the expected output register.
  logic        m_bits[64];
  int          m_n = 0;
  logic        m_valid = 0, m_cmd = 0, m_ovr = 0, m_perr = 0;
  logic [31:0] m_da = 0, m_db = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("valid_a", {31'b0, valid_a}, {31'b0, m_valid});
    chk("valid_b", {31'b0, valid_b}, {31'b0, m_valid});
    chk("data_a",  32'(data_a), m_da);
    chk("data_b",  32'(data_b), m_db);
    chk("cmd_a",   {31'b0, cmd_a}, {31'b0, m_cmd});
    chk("cmd_b",   {31'b0, cmd_b}, {31'b0, m_cmd});
    chk("ovr_a",   {31'b0, ovr_a}, {31'b0, m_ovr});
    chk("ovr_b",   {31'b0, ovr_b}, {31'b0, m_ovr});
`ifdef DESER_PARITY_EN
    chk("perr_a",  {31'b0, perr_a}, {31'b0, m_perr});
    chk("perr_b",  {31'b0, perr_b}, {31'b0, m_perr});
`endif
  endtask

  // One clock: model consumes this cycle's inputs, then outputs are compared after the edge.
  task automatic step();
    logic        comp, x;
    logic [31:0] da, db;
    comp = 1'b0;
    if (m_n == 0) begin
      if (data_val) begin m_bits[0] = ser; m_n = 1; end
    end else begin
      m_bits[m_n] = ser;
      m_n++;
      if (m_n == FL) begin comp = 1'b1; m_n = 0; end
    end
    m_ovr = 1'b0;
    if (comp) begin
      da = 0; db = 0; x = 1'b0;
      for (int i = 0; i < W; i++) begin
        da[W-1-i] = m_bits[i];
        db[i]     = m_bits[i];
      end
      for (int i = 0; i < FL; i++) x ^= m_bits[i];
      if (!m_valid || rdy) begin
        m_valid = 1'b1; m_da = da; m_db = db; m_cmd = m_bits[W]; m_perr = ~x;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outs();
    if (ovr_a) n_ovr++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; data_val = 1'b0; rdy = 1'b0; ser = 1'b0;
    #2;
    m_n = 0; m_valid = 0; m_cmd = 0; m_ovr = 0; m_perr = 0; m_da = 0; m_db = 0;
    chk("rst_valid", {31'b0, valid_a | valid_b}, 32'd0);
    chk("rst_data",  32'(data_a) | 32'(data_b), 32'd0);
    chk("rst_cmd",   {31'b0, cmd_a | cmd_b}, 32'd0);
    chk("rst_ovr",   {31'b0, ovr_a | ovr_b}, 32'd0);
`ifdef DESER_PARITY_EN
    chk("rst_perr",  {31'b0, perr_a | perr_b}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // fr[i] is the i-th serial bit of the frame; rdy is driven high only on the last bit.
  task automatic send_frame(input logic [63:0] fr, input logic rdy_last);
    for (int i = 0; i < FL; i++) begin
      data_val = (i == 0);
      ser      = fr[i];
      rdy      = (i == FL - 1) ? rdy_last : 1'b0;
      step();
    end
    data_val = 1'b0; rdy = 1'b0;
  endtask

  function automatic logic [63:0] rand_frame();
    logic [63:0] f;
    f = 0;
    for (int i = 0; i < FL; i++) f[i] = 1'($urandom);
    return f;
  endfunction

  initial begin
    logic [63:0] f1, f2;
    int          ovr0;
    rst_n = 1'b0; data_val = 1'b0; ser = 1'b0; rdy = 1'b0;
    do_reset();

`ifdef DESER_PARITY_EN
    // 8'hA5 sent MSB first, cmd 0: parity 0 gives an even total, so the check fails.
    f1 = 0;
    for (int i = 0; i < W; i++) f1[i] = (i == 0 || i == 2 || i == 5 || i == 7);
    send_frame(f1, 1'b1);
    chk("par_bad_err",  {31'b0, perr_a}, 32'd1);
    chk("par_bad_data", 32'(data_a), 32'hA5);
    f1[W+1] = 1'b1;
    send_frame(f1, 1'b1);
    chk("par_ok_err",   {31'b0, perr_a}, 32'd0);
    chk("par_ok_valid", {31'b0, valid_a}, 32'd1);
`else
    // Stream 1,0,1,1,0 then cmd 1.
    f1 = 64'b1_01101;
    for (int i = 0; i < FL; i++) begin
      data_val = (i == 0); ser = f1[i]; rdy = 1'b1;
      step();
      if (i == FL - 2) chk("lat_before", {31'b0, valid_a}, 32'd0);
    end
    data_val = 1'b0; rdy = 1'b0;
    chk("lat_valid", {31'b0, valid_a}, 32'd1);
    chk("msb_data",  32'(data_a), 32'b10110);
    chk("lsb_data",  32'(data_b), 32'b01101);
    chk("cmd",       {31'b0, cmd_a}, 32'd1);
`endif
    rdy = 1'b1; step(); rdy = 1'b0; step();

    // Back-to-back frames, consumer stalled: second frame is dropped.
    f1 = rand_frame(); f2 = rand_frame();
    ovr0 = n_ovr;
    send_frame(f1, 1'b0);
    send_frame(f2, 1'b0);
    chk("ovr_once",  32'(n_ovr - ovr0), 32'd1);
    chk("held_data", 32'(data_a), m_da);
    for (int i = 0; i < W; i++) f1[W-1-i] = f1[i];
    repeat (2) step();

    // Completion coinciding with acceptance replaces the held frame.
    f2 = rand_frame();
    ovr0 = n_ovr;
    send_frame(f2, 1'b1);
    chk("swap_no_ovr", 32'(n_ovr - ovr0), 32'd0);
    for (int i = 0; i < W; i++) f1[i] = f2[W-1-i];
    chk("swap_data",   32'(data_a), 32'(f1[W-1:0]));
    chk("swap_valid",  {31'b0, valid_a}, 32'd1);

    // Abort after three payload bits.
    for (int i = 0; i < 3; i++) begin
      data_val = (i == 0); ser = 1'($urandom); step();
    end
    ovr0 = n_ovr;
    do_reset();
    repeat (FL) step();
    chk("abort_valid", {31'b0, valid_a}, 32'd0);
    chk("abort_ovr",   32'(n_ovr - ovr0), 32'd0);
    f2 = rand_frame();
    send_frame(f2, 1'b1);
    chk("post_rst_valid", {31'b0, valid_b}, 32'd1);
    chk("post_rst_data",  32'(data_b), 32'(f2[W-1:0]));

    // Random traffic, including starts while busy and stalled consumers.
    for (int c = 0; c < 600; c++) begin
      data_val = ($urandom_range(0, 2) == 0);
      ser      = 1'($urandom);
      rdy      = ($urandom_range(0, 3) != 0) ? ((c % 80) < 50) : 1'b0;
      step();
    end
    data_val = 1'b0; rdy = 1'b1;
    repeat (FL + 2) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
